// File: rtl/zx_bus_pkg.sv
// Shared types for the Z80 bus arbiter and the memory address/data mux.
package zx_bus_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReq     = 3'd1,
      StGrant   = 3'd2,
      StRelease = 3'd3,
      StHoldoff = 3'd4
   } zx_bus_state_e;

   // Owner encodings seen by the memory mux select.
   localparam logic BUS_OWNER_CPU = 1'b0;
   localparam logic BUS_OWNER_DMA = 1'b1;

endpackage

// File: rtl/zx_bus_arbiter.sv
// Z80 bus arbiter: hands the memory bus to one DMA requester via the CPU busrq_n/busak_n
// handshake, caps each tenure at MAX_BURST accesses and then lets the CPU run for HOLDOFF
// cen_p ticks before the next request, so the CPU always makes forward progress.
module zx_bus_arbiter
   import zx_bus_pkg::*;
#(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned HOLDOFF   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cen_p,
   input  logic       dma_req,
   input  logic       dma_strobe,
   input  logic       dma_done,
   input  logic       busak_n,
   output logic       busrq_n,
   output logic       dma_grant,
   output logic       bus_owner,
   output logic [7:0] burst_cnt
);

   localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF);
   localparam logic [8:0] MaxBurst = 9'(MAX_BURST);

   zx_bus_state_e    state_q, state_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic             busrq_n_q, busrq_n_d;
   logic             dma_grant_q, dma_grant_d;
   logic             bus_owner_q, bus_owner_d;
   logic [8:0]       burst_inc;

   // Next state, counters, and registered outputs decoded from the next state.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      // 9 bits so the limit compare cannot alias on wrap.
      burst_inc   = {1'b0, burst_cnt_q} + 9'd1;

      unique case (state_q)
         StIdle: begin
            if (dma_req) state_d = StReq;
         end
         StReq: begin
            if (!busak_n && dma_req) begin
               state_d     = StGrant;
               burst_cnt_d = '0;
            end else if (!dma_req) begin
               state_d = StRelease;
            end
         end
         StGrant: begin
            // The limiting strobe is still counted, so burst_cnt reads MAX_BURST afterwards.
            if (dma_strobe) burst_cnt_d = burst_inc[7:0];
            if (dma_done || !dma_req || (dma_strobe && (burst_inc == MaxBurst))) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            if (busak_n) begin
               if (HOLDOFF == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d    = StHoldoff;
                  hold_cnt_d = HoldLoad;
               end
            end
         end
         StHoldoff: begin
            // dma_req is deliberately ignored here.
            if (cen_p) begin
               hold_cnt_d = hold_cnt_q - HoldW'(1);
               if (hold_cnt_q == HoldW'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busrq_n_d   = !((state_d == StReq) || (state_d == StGrant));
      dma_grant_d = (state_d == StGrant);
      bus_owner_d = (state_d == StGrant) ? BUS_OWNER_DMA : BUS_OWNER_CPU;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         burst_cnt_q <= '0;
         hold_cnt_q  <= '0;
         busrq_n_q   <= 1'b1;
         dma_grant_q <= 1'b0;
         bus_owner_q <= BUS_OWNER_CPU;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         busrq_n_q   <= busrq_n_d;
         dma_grant_q <= dma_grant_d;
         bus_owner_q <= bus_owner_d;
      end
   end

   assign busrq_n   = busrq_n_q;
   assign dma_grant = dma_grant_q;
   assign bus_owner = bus_owner_q;
   assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_zx_bus_arbiter.sv
// Bench for zx_bus_arbiter: DUT A (MAX_BURST=4, HOLDOFF=4) and DUT B (MAX_BURST=16,
// HOLDOFF=0). Stimulus pushes expected outputs tagged with a cycle number; a negedge monitor
// pops and compares them.
module tb_zx_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cen_p_a, dma_req_a, dma_strobe_a, dma_done_a, busak_n_a;
   logic       busrq_n_a, dma_grant_a, bus_owner_a;
   logic [7:0] burst_cnt_a;
   logic       cen_p_b, dma_req_b, dma_strobe_b, dma_done_b, busak_n_b;
   logic       busrq_n_b, dma_grant_b, bus_owner_b;
   logic [7:0] burst_cnt_b;

   typedef struct {
      int         cyc;
      bit         dut;
      string      name;
      logic       rq;
      logic       gnt;
      logic       own;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   zx_bus_arbiter #(.MAX_BURST(4), .HOLDOFF(4)) u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .cen_p      (cen_p_a),
      .dma_req    (dma_req_a),
      .dma_strobe (dma_strobe_a),
      .dma_done   (dma_done_a),
      .busak_n    (busak_n_a),
      .busrq_n    (busrq_n_a),
      .dma_grant  (dma_grant_a),
      .bus_owner  (bus_owner_a),
      .burst_cnt  (burst_cnt_a)
   );

   zx_bus_arbiter #(.MAX_BURST(16), .HOLDOFF(0)) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .cen_p      (cen_p_b),
      .dma_req    (dma_req_b),
      .dma_strobe (dma_strobe_b),
      .dma_done   (dma_done_b),
      .busak_n    (busak_n_b),
      .busrq_n    (busrq_n_b),
      .dma_grant  (dma_grant_b),
      .bus_owner  (bus_owner_b),
      .burst_cnt  (burst_cnt_b)
   );

   always #5 clk = ~clk;

   // Cycle stamp: number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      exp_t e;
      logic       rq, gnt, own;
      logic [7:0] cnt;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.dut) begin
            rq = busrq_n_b; gnt = dma_grant_b; own = bus_owner_b; cnt = burst_cnt_b;
         end else begin
            rq = busrq_n_a; gnt = dma_grant_a; own = bus_owner_a; cnt = burst_cnt_a;
         end
         checks++;
         if (e.cyc != cyc || rq !== e.rq || gnt !== e.gnt || own !== e.own || cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s (dut %0d, cyc %0d/%0d): got busrq_n=%b dma_grant=%b bus_owner=%b burst_cnt=%0d, expected %b %b %b %0d",
                     e.name, e.dut, cyc, e.cyc, rq, gnt, own, cnt, e.rq, e.gnt, e.own, e.cnt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input bit dut, input string name, input logic rq, input logic gnt,
                      input logic own, input logic [7:0] cnt);
      exp_t e;
      logic       g_rq, g_gnt, g_own;
      logic [7:0] g_cnt;
      e.cyc = cyc; e.dut = dut; e.name = name;
      e.rq = rq; e.gnt = gnt; e.own = own; e.cnt = cnt;
      sb.push_back(e);
      if (dut) begin
         g_rq = busrq_n_b; g_gnt = dma_grant_b; g_own = bus_owner_b; g_cnt = burst_cnt_b;
      end else begin
         g_rq = busrq_n_a; g_gnt = dma_grant_a; g_own = bus_owner_a; g_cnt = burst_cnt_a;
      end
      checks++;
      if (g_rq !== rq || g_gnt !== gnt || g_own !== own || g_cnt !== cnt) begin
         errors++;
         $display("FAIL %s (dut %0d, cyc %0d, immediate): got busrq_n=%b dma_grant=%b bus_owner=%b burst_cnt=%0d, expected %b %b %b %0d",
                  name, dut, cyc, g_rq, g_gnt, g_own, g_cnt, rq, gnt, own, cnt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      cen_p_a = 1'b0; dma_req_a = 1'b0; dma_strobe_a = 1'b0; dma_done_a = 1'b0;
      busak_n_a = 1'b1;
      cen_p_b = 1'b0; dma_req_b = 1'b0; dma_strobe_b = 1'b0; dma_done_b = 1'b0;
      busak_n_b = 1'b1;
      step(); step();
      chk(0, "reset_a", 1, 0, 0, 0);
      chk(1, "reset_b", 1, 0, 0, 0);
      reset_n = 1'b1;

      // Basic grant: CPU acknowledges a few clocks after busrq_n.
      dma_req_a = 1'b1;
      step(); chk(0, "grant_req", 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(); chk(0, "grant_wait", 0, 0, 0, 0);
      end
      busak_n_a = 1'b0;
      step(); chk(0, "grant_on", 0, 1, 1, 0);

      // Burst limit at 4; strobes 5 and 6 land in RELEASE and are not counted.
      dma_strobe_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(); chk(0, "burst_cnt", 0, 1, 1, 8'(i));
      end
      step(); chk(0, "burst_limit", 1, 0, 0, 4);
      for (int i = 0; i < 2; i++) begin
         step(); chk(0, "burst_over", 1, 0, 0, 4);
      end
      dma_strobe_a = 1'b0;
      busak_n_a = 1'b1;
      step(); chk(0, "holdoff_in", 1, 0, 0, 4);
      step(); chk(0, "holdoff_gate", 1, 0, 0, 4);
      cen_p_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); chk(0, "holdoff_tick", 1, 0, 0, 4);
      end
      step(); chk(0, "holdoff_rereq", 0, 0, 0, 4);

      // Early done: strobe and done together at count 1.
      busak_n_a = 1'b0;
      step(); chk(0, "done_grant", 0, 1, 1, 0);
      dma_strobe_a = 1'b1;
      step(); chk(0, "done_cnt1", 0, 1, 1, 1);
      dma_done_a = 1'b1;
      step(); chk(0, "done_exit", 1, 0, 0, 2);
      dma_strobe_a = 1'b0; dma_done_a = 1'b0; dma_req_a = 1'b0; busak_n_a = 1'b1;
      step(); chk(0, "done_holdoff", 1, 0, 0, 2);
      for (int i = 0; i < 5; i++) begin
         step(); chk(0, "done_idle", 1, 0, 0, 2);
      end

      // Withdrawn request, then dma_req ignored during holdoff.
      dma_req_a = 1'b1;
      step(); chk(0, "wd_req", 0, 0, 0, 2);
      dma_req_a = 1'b0;
      step(); chk(0, "wd_release", 1, 0, 0, 2);
      step(); chk(0, "wd_holdoff", 1, 0, 0, 2);
      dma_req_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); chk(0, "wd_ignore", 1, 0, 0, 2);
      end
      step(); chk(0, "wd_rereq", 0, 0, 0, 2);

      // Reset mid-grant at burst_cnt=3.
      busak_n_a = 1'b0;
      step(); chk(0, "rg_grant", 0, 1, 1, 0);
      dma_strobe_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(); chk(0, "rg_cnt", 0, 1, 1, 8'(i));
      end
      dma_strobe_a = 1'b0;
      reset_n = 1'b0;
      step(); chk(0, "rg_reset", 1, 0, 0, 0);
      reset_n = 1'b1; dma_req_a = 1'b0; busak_n_a = 1'b1;
      step(); chk(0, "rg_idle", 1, 0, 0, 0);

      // Spurious busak_n while busrq_n is high must not grant.
      busak_n_a = 1'b0;
      step(); chk(0, "fault_idle", 1, 0, 0, 0);
      dma_req_a = 1'b1;
      step(); chk(0, "fault_req", 0, 0, 0, 0);
      step(); chk(0, "fault_grant", 0, 1, 1, 0);
      dma_req_a = 1'b0;
      step(); chk(0, "fault_rel", 1, 0, 0, 0);
      busak_n_a = 1'b1;

      // DUT B, HOLDOFF=0, cen_p held at 0: back-to-back requests.
      dma_req_b = 1'b1;
      step(); chk(1, "b_req", 0, 0, 0, 0);
      busak_n_b = 1'b0;
      step(); chk(1, "b_grant", 0, 1, 1, 0);
      dma_strobe_b = 1'b1;
      step(); chk(1, "b_cnt1", 0, 1, 1, 1);
      dma_strobe_b = 1'b0; dma_req_b = 1'b0;
      step(); chk(1, "b_rel", 1, 0, 0, 1);
      dma_req_b = 1'b1;
      step(); chk(1, "b_rel_hold", 1, 0, 0, 1);
      busak_n_b = 1'b1;
      step(); chk(1, "b_idle", 1, 0, 0, 1);
      step(); chk(1, "b_rereq", 0, 0, 0, 1);

      // DUT B burst limit at 16.
      busak_n_b = 1'b0;
      step(); chk(1, "b_grant2", 0, 1, 1, 0);
      dma_strobe_b = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step(); chk(1, "b_cnt", 0, 1, 1, 8'(i));
      end
      step(); chk(1, "b_limit", 1, 0, 0, 16);
      dma_strobe_b = 1'b0;

      step(); step();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d pending expectations, expected 0", sb.size());
      end
      if (checks == 0) begin
         errors++;
         $display("FAIL checks: got 0 checks performed, expected more than 0");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
